// File: rtl/sort_frame_loader.sv
// Frame loader feeding the combinational bubble sorter.
// Collects up to DIM elements, pads short frames with all-ones, holds until released.
module sort_frame_loader #(
    parameter int DIM   = 4,
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(DIM + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [DIM*WIDTH-1:0] prand,
    output logic [CNTW-1:0]      frame_count,
    output logic                 frame_valid,
    input  logic                 frame_ready
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                        state;
    logic [CNTW-1:0]               idx;
    logic [DIM-1:0][WIDTH-1:0]     slots;
    logic                          closing;

    assign prand       = slots;
    assign in_ready    = (state == FILL);
    assign frame_valid = (state == HOLD);

    // the frame closes on its DIM-th element or an earlier qualified in_last
    assign closing = (idx == CNTW'(DIM - 1)) || in_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            idx         <= '0;
            slots       <= '1;
            frame_count <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        for (int i = 0; i < DIM; i++) begin
                            if (idx == CNTW'(i)) slots[i] <= in_data;
                        end
                        idx <= idx + CNTW'(1);
                        if (closing) begin
                            state       <= HOLD;
                            frame_count <= idx + CNTW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        state       <= FILL;
                        idx         <= '0;
                        slots       <= '1;
                        frame_count <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_frame_loader.sv
// Scoreboard bench for sort_frame_loader.
// Reference frames come from the element stream alone; a monitor checks each held frame.
module tb_sort_frame_loader;

    localparam int DIM   = 4;
    localparam int WIDTH = 8;
    localparam int CNTW  = $clog2(DIM + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [DIM*WIDTH-1:0] prand;
    logic [CNTW-1:0]      frame_count;
    logic                 frame_valid;
    logic                 frame_ready;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [WIDTH-1:0]           pend[$];
    logic [DIM*WIDTH+CNTW-1:0]  exp_q[$];
    int                         rise_q[$];
    bit                         rnd_on = 1'b0;

    sort_frame_loader #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .prand       (prand),
        .frame_count (frame_count),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // reference: elements gather into a frame until DIM of them or a last flag
    task automatic model_elem(input logic [WIDTH-1:0] d, input logic l);
        logic [DIM*WIDTH-1:0] f;
        pend.push_back(d);
        if (pend.size() == DIM || l) begin
            f = '1;
            for (int i = 0; i < pend.size(); i++)
                f[i*WIDTH +: WIDTH] = pend[i];
            exp_q.push_back({CNTW'(pend.size()), f});
            pend.delete();
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 60);
        chk("send_timeout", 64'(acc), 64'd1);
        if (acc) model_elem(d, l);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor: pops a reference frame on each rise, then demands it stays frozen
    initial begin : monitor
        logic                      prev_fv;
        logic [DIM*WIDTH-1:0]      held_p;
        logic [CNTW-1:0]           held_c;
        logic [DIM*WIDTH+CNTW-1:0] e;
        prev_fv = 1'b0;
        held_p  = '0;
        held_c  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_fv = 1'b0;
            end else begin
                if (frame_valid && !prev_fv) begin
                    rise_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 64'(prand), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_prand", 64'(prand), 64'(e[DIM*WIDTH-1:0]));
                        chk("frame_count", 64'(frame_count),
                            64'(e[DIM*WIDTH +: CNTW]));
                    end
                    held_p = prand;
                    held_c = frame_count;
                end else if (frame_valid) begin
                    chk("hold_prand", 64'(prand), 64'(held_p));
                    chk("hold_count", 64'(frame_count), 64'(held_c));
                end
                if (frame_valid)
                    chk("hold_in_ready", 64'(in_ready), 64'd0);
                prev_fv = frame_valid;
            end
        end
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_data     = '0;
        frame_ready = 1'b1;
        #12 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fv", 64'(frame_valid), 64'd0);
        chk("rst_prand", 64'(prand), 64'hFFFFFFFF);
        chk("rst_count", 64'(frame_count), 64'd0);
        @(posedge clk);
        #1;

        // full frame, single-cycle hold
        send(8'h30, 1'b0);
        send(8'h10, 1'b0);
        send(8'h40, 1'b0);
        send(8'h20, 1'b0);
        chk("full_fv", 64'(frame_valid), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_prand", 64'(prand), 64'h20401030);
        chk("full_count", 64'(frame_count), 64'd4);
        idle(1);
        chk("full_fv_drop", 64'(frame_valid), 64'd0);

        // short frame with padding
        send(8'h05, 1'b0);
        send(8'h02, 1'b1);
        chk("short_prand", 64'(prand), 64'hFFFF0205);
        chk("short_count", 64'(frame_count), 64'd2);
        idle(1);

        // in_last on the first element
        send(8'hFF, 1'b1);
        chk("one_prand", 64'(prand), 64'hFFFFFFFF);
        chk("one_count", 64'(frame_count), 64'd1);
        idle(1);

        // backpressure with a waiting element
        frame_ready = 1'b0;
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hD4, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_prand", 64'(prand), 64'hD4C3B2A1);
        end
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        chk("bp_release_prand", 64'(prand), 64'hFFFFFFFF);
        chk("bp_release_fv", 64'(frame_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("bp_accept_77", 64'(prand), 64'hFFFFFF77);
        model_elem(8'h77, 1'b0);
        in_valid    = 1'b0;
        frame_ready = 1'b1;
        send(8'h78, 1'b0);
        send(8'h79, 1'b1);
        idle(1);

        // gaps with unqualified in_last
        begin
            logic       gv[7];
            logic [7:0] gd[7];
            int         k;
            gv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            k  = 1;
            for (int i = 0; i < 7; i++) begin
                in_valid = gv[i];
                in_last  = !gv[i];
                in_data  = gv[i] ? 8'(k) : 8'hEE;
                if (gv[i]) begin
                    model_elem(8'(k), 1'b0);
                    k++;
                end
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk("gap_prand", 64'(prand), 64'h04030201);
            chk("gap_count", 64'(frame_count), 64'd4);
            idle(1);
        end

        // asynchronous reset mid-fill
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_fv", 64'(frame_valid), 64'd0);
        chk("arst_prand", 64'(prand), 64'hFFFFFFFF);
        chk("arst_count", 64'(frame_count), 64'd0);
        pend.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'h9A, 1'b0);
        send(8'h9B, 1'b0);
        send(8'h9C, 1'b0);
        send(8'h9D, 1'b0);
        chk("arst_clean", 64'(prand), 64'h9D9C9B9A);
        idle(1);

        // back-to-back full frames
        rise_q.delete();
        for (int i = 0; i < 3 * DIM; i++)
            send(8'($urandom), 1'b0);
        idle(2);
        chk("b2b_frames", 64'(rise_q.size()), 64'd3);
        if (rise_q.size() == 3) begin
            chk("b2b_period1", 64'(rise_q[1] - rise_q[0]), 64'd5);
            chk("b2b_period2", 64'(rise_q[2] - rise_q[1]), 64'd5);
        end

        // randomized streams with random release timing
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                frame_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            send(8'($urandom), ($urandom_range(0, 3) == 0));
        end
        if (pend.size() != 0) send(8'($urandom), 1'b1);
        rnd_on = 1'b0;
        @(posedge clk);
        #2 frame_ready = 1'b1;

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(posedge clk);
                n++;
            end
            chk("drain_left", 64'(exp_q.size()), 64'd0);
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
